// File: rtl/alarm_ctl.sv
// Alarm stage behind the 12-hour clock core: alarm time edit, match detect, IDLE/ARMED/RINGING/SNOOZE control, beeper drive.
// Latency: match edge -> ringing/buzz on the next clk edge; alarm edits visible one clk after the pulse.
// Backpressure: none; all pulse inputs are consumed in the clk they arrive, and edits are ignored while ringing/snoozing.
module alarm_ctl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 9
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_sec_i,
    input  logic [3:0] cur_hr_tens_i,
    input  logic [3:0] cur_hr_ones_i,
    input  logic [3:0] cur_min_tens_i,
    input  logic [3:0] cur_min_ones_i,
    input  logic       cur_pm_i,
    input  logic       alarm_en_i,
    input  logic       set_mode_i,
    input  logic       inc_hr_i,
    input  logic       inc_min_i,
    input  logic       snooze_i,
    input  logic       stop_i,
    output logic [3:0] al_hr_tens_o,
    output logic [3:0] al_hr_ones_o,
    output logic [3:0] al_min_tens_o,
    output logic [3:0] al_min_ones_o,
    output logic       al_pm_o,
    output logic       buzz_o,
    output logic       ringing_o,
    output logic       snoozing_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_e;

    localparam int         SNOOZE_SEC  = SNOOZE_MIN * 60;
    localparam logic [9:0] RING_LAST   = 10'(RING_SEC - 1);
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SEC - 1);

    // The second counter is 10 bits wide; both durations must fit in it.
    if (RING_SEC < 1 || RING_SEC > 1023) begin : g_ring_sec_chk
        $error("alarm_ctl: RING_SEC must be in 1..1023");
    end
    if (SNOOZE_SEC < 1 || SNOOZE_SEC > 1023) begin : g_snooze_sec_chk
        $error("alarm_ctl: SNOOZE_MIN*60 must be in 1..1023");
    end

    state_e     state_q, state_d;
    logic [9:0] sec_cnt_q, sec_cnt_d;
    logic       beep_q, beep_d;
    logic       match_prev_q;

    logic [3:0] al_hr_tens_q, al_hr_tens_d;
    logic [3:0] al_hr_ones_q, al_hr_ones_d;
    logic [3:0] al_min_tens_q, al_min_tens_d;
    logic [3:0] al_min_ones_q, al_min_ones_d;
    logic       al_pm_q, al_pm_d;

    logic edit_en;
    logic match;
    logic fire;

    // Editing is only meaningful while not actively alarming.
    assign edit_en = set_mode_i & ((state_q == ST_IDLE) | (state_q == ST_ARMED));

    // Full-time compare including AM/PM; the previous value gives a rising-edge fire.
    assign match = (cur_hr_tens_i  == al_hr_tens_q)  &
                   (cur_hr_ones_i  == al_hr_ones_q)  &
                   (cur_min_tens_i == al_min_tens_q) &
                   (cur_min_ones_i == al_min_ones_q) &
                   (cur_pm_i       == al_pm_q);
    assign fire  = match & ~match_prev_q & ~set_mode_i;

    // Alarm time edit: 12-hour BCD hour wrap with AM/PM toggle at 11->12, minute wraps without carry.
    always_comb begin
        al_hr_tens_d  = al_hr_tens_q;
        al_hr_ones_d  = al_hr_ones_q;
        al_min_tens_d = al_min_tens_q;
        al_min_ones_d = al_min_ones_q;
        al_pm_d       = al_pm_q;

        if (edit_en && inc_hr_i) begin
            if (al_hr_tens_q == 4'd1) begin
                case (al_hr_ones_q)
                    4'd2: begin
                        al_hr_tens_d = 4'd0;
                        al_hr_ones_d = 4'd1;
                    end
                    4'd1: begin
                        al_hr_ones_d = 4'd2;
                        al_pm_d      = ~al_pm_q;
                    end
                    default: al_hr_ones_d = al_hr_ones_q + 4'd1;
                endcase
            end else if (al_hr_ones_q == 4'd9) begin
                al_hr_tens_d = 4'd1;
                al_hr_ones_d = 4'd0;
            end else begin
                al_hr_ones_d = al_hr_ones_q + 4'd1;
            end
        end

        if (edit_en && inc_min_i) begin
            if (al_min_ones_q == 4'd9) begin
                al_min_ones_d = 4'd0;
                al_min_tens_d = (al_min_tens_q == 4'd5) ? 4'd0 : al_min_tens_q + 4'd1;
            end else begin
                al_min_ones_d = al_min_ones_q + 4'd1;
            end
        end
    end

    // Next state: alarm_en low beats stop, which beats snooze, which beats timeouts and fire.
    always_comb begin
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
        beep_d    = beep_q;

        if (!alarm_en_i) begin
            state_d   = ST_IDLE;
            sec_cnt_d = 10'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Arming takes a clk; a match in that same clk is not acted on.
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (fire) begin
                        state_d   = ST_RINGING;
                        sec_cnt_d = 10'd0;
                        beep_d    = 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (stop_i) begin
                        state_d = ST_ARMED;
                    end else if (snooze_i) begin
                        state_d   = ST_SNOOZE;
                        sec_cnt_d = 10'd0;
                    end else if (tick_sec_i) begin
                        beep_d = ~beep_q;
                        if (sec_cnt_q == RING_LAST) begin
                            state_d   = ST_ARMED;
                            sec_cnt_d = 10'd0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 10'd1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    // A snooze pulse here is deliberately ignored; the snooze period is not extended.
                    if (stop_i) begin
                        state_d = ST_ARMED;
                    end else if (tick_sec_i) begin
                        if (sec_cnt_q == SNOOZE_LAST) begin
                            state_d   = ST_RINGING;
                            sec_cnt_d = 10'd0;
                            beep_d    = 1'b1;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 10'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state, second counter and beep phase; match history starts at 1 so reset never fires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            sec_cnt_q    <= 10'd0;
            beep_q       <= 1'b1;
            match_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            beep_q       <= beep_d;
            match_prev_q <= match;
        end
    end

    // Alarm time registers, reset to 12:00 AM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            al_hr_tens_q  <= 4'd1;
            al_hr_ones_q  <= 4'd2;
            al_min_tens_q <= 4'd0;
            al_min_ones_q <= 4'd0;
            al_pm_q       <= 1'b0;
        end else begin
            al_hr_tens_q  <= al_hr_tens_d;
            al_hr_ones_q  <= al_hr_ones_d;
            al_min_tens_q <= al_min_tens_d;
            al_min_ones_q <= al_min_ones_d;
            al_pm_q       <= al_pm_d;
        end
    end

    // Outputs decode straight from registers, so an async reset clears buzz immediately.
    assign al_hr_tens_o  = al_hr_tens_q;
    assign al_hr_ones_o  = al_hr_ones_q;
    assign al_min_tens_o = al_min_tens_q;
    assign al_min_ones_o = al_min_ones_q;
    assign al_pm_o       = al_pm_q;
    assign ringing_o     = (state_q == ST_RINGING);
    assign snoozing_o    = (state_q == ST_SNOOZE);
    assign buzz_o        = (state_q == ST_RINGING) & beep_q;

endmodule
